// File: rtl/pwm_pkg.sv
//------------------------------------------------------------------------------
// Module   : pwm_pkg
// Brief    : Shared duty width default and fader state encoding for the pwm
//            and pwm_fader blocks, so duty widths stay consistent.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package pwm_pkg;

  // Default duty width shared by pwm and pwm_fader
  localparam int unsigned c_DUTY_W = 8;

  // Fader control states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } fade_state_t;

endpackage

`default_nettype wire

// File: rtl/fade_tick_gen.sv
//------------------------------------------------------------------------------
// Module   : fade_tick_gen
// Brief    : Loadable, auto-reloading down-counter. Produces a one-cycle tick
//            while enabled and the count is zero, then reloads the divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module fade_tick_gen
  import pwm_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;

  assign tick = en && (r_count == '0);

  // Count down while enabled; a load always wins and restarts the interval
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= div;
    end else if (en) begin
      r_count <= (r_count == '0) ? div : r_count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_fader.sv
//------------------------------------------------------------------------------
// Module   : pwm_fader
// Brief    : Duty-cycle ramp controller feeding pwm.duty. Accepts a fade
//            command (target, step, interval) and walks the registered duty
//            toward the target one step per interval, pulsing done on arrival.
//            Optional macro PWM_FADER_BREATHE_EN adds a 'breathe' input that
//            ping-pongs between the start duty and the target indefinitely.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pwm_fader
  import pwm_pkg::*;
#(
  parameter int DUTY_W = c_DUTY_W,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [DUTY_W-1:0] cmd_step,
  input  logic [DIV_W-1:0]  cmd_div,
`ifdef PWM_FADER_BREATHE_EN
  input  logic              breathe,
`endif
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  fade_state_t       r_state, w_state_d;
  logic [DUTY_W-1:0] r_duty, w_duty_d;
  logic [DUTY_W-1:0] r_target, w_target_d;
  logic [DUTY_W-1:0] r_step, w_step_d;
  logic [DIV_W-1:0]  r_div, w_div_d;
  logic              r_done, w_done_d;
`ifdef PWM_FADER_BREATHE_EN
  logic [DUTY_W-1:0] r_start, w_start_d;
  logic              r_breathe, w_breathe_d;
`endif

  logic              w_accept;
  logic              w_tick;
  logic [DIV_W-1:0]  w_div_sel;
  logic [DUTY_W-1:0] w_step_in;
  logic              w_dir_up;
  logic [DUTY_W:0]   w_dist;
  logic              w_last;
  logic [DUTY_W:0]   w_next;

  assign w_accept  = (r_state == ST_IDLE) && cmd_valid;
  assign w_step_in = (cmd_step == '0) ? {{(DUTY_W-1){1'b0}}, 1'b1} : cmd_step;
  // The interval counter loads the fresh divider on accept, reloads the
  // latched one on every tick after that
  assign w_div_sel = w_accept ? cmd_div : r_div;

  // One-bit-wider distance and next value so comparisons never wrap
  assign w_dir_up = (r_target > r_duty);
  assign w_dist   = w_dir_up ? ({1'b0, r_target} - {1'b0, r_duty})
                             : ({1'b0, r_duty} - {1'b0, r_target});
  assign w_last   = (w_dist <= {1'b0, r_step});
  assign w_next   = w_dir_up ? ({1'b0, r_duty} + {1'b0, r_step})
                             : ({1'b0, r_duty} - {1'b0, r_step});

  fade_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (w_accept),
    .en   (r_state == ST_RAMP),
    .div  (w_div_sel),
    .tick (w_tick)
  );

  // Next-state and step arithmetic; abort takes priority over any step
  always_comb begin
    w_state_d   = r_state;
    w_duty_d    = r_duty;
    w_target_d  = r_target;
    w_step_d    = r_step;
    w_div_d     = r_div;
    w_done_d    = 1'b0;
`ifdef PWM_FADER_BREATHE_EN
    w_start_d   = r_start;
    w_breathe_d = r_breathe;
`endif
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_target_d = cmd_target;
          w_step_d   = w_step_in;
          w_div_d    = cmd_div;
`ifdef PWM_FADER_BREATHE_EN
          w_start_d   = r_duty;
          w_breathe_d = breathe;
`endif
          if (cmd_target == r_duty) begin
            w_done_d = 1'b1;
          end else begin
            w_state_d = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        if (abort) begin
          w_state_d = ST_IDLE;
        end else if (w_tick) begin
          if (w_last) begin
            w_duty_d = r_target;
            w_done_d = 1'b1;
`ifdef PWM_FADER_BREATHE_EN
            if (r_breathe) begin
              w_target_d = r_start;
              w_start_d  = r_target;
            end else begin
              w_state_d = ST_IDLE;
            end
`else
            w_state_d = ST_IDLE;
`endif
          end else begin
            // Carry bit cannot be set on a non-final step; clamp defensively
            w_duty_d = w_next[DUTY_W] ? r_target : w_next[DUTY_W-1:0];
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  // State and latched-command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_duty    <= '0;
      r_target  <= '0;
      r_step    <= '0;
      r_div     <= '0;
      r_done    <= 1'b0;
`ifdef PWM_FADER_BREATHE_EN
      r_start   <= '0;
      r_breathe <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_duty    <= w_duty_d;
      r_target  <= w_target_d;
      r_step    <= w_step_d;
      r_div     <= w_div_d;
      r_done    <= w_done_d;
`ifdef PWM_FADER_BREATHE_EN
      r_start   <= w_start_d;
      r_breathe <= w_breathe_d;
`endif
    end
  end

  assign duty      = r_duty;
  assign done      = r_done;
  assign busy      = (r_state == ST_RAMP);
  assign cmd_ready = (r_state == ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pwm_fader.sv
//------------------------------------------------------------------------------
// Module   : tb_pwm_fader
// Brief    : Scoreboard bench for pwm_fader. Stimulus pushes expected
//            (duty, done, cycle) events; a monitor pops and compares each time
//            duty changes or done pulses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pwm_fader;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_target;
  logic [7:0]  cmd_step;
  logic [15:0] cmd_div;
  logic        abort;
  logic [7:0]  duty;
  logic        busy;
  logic        done;
`ifdef PWM_FADER_BREATHE_EN
  logic        breathe;
`endif

  typedef struct {
    logic [7:0] duty;
    logic       done;
    int         cyc;
  } ev_t;

  ev_t  q[$];
  int   cyc;
  int   checks;
  int   errors;
  int   a;
  logic [7:0] prev;

  pwm_fader #(.DUTY_W(8), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .cmd_div    (cmd_div),
`ifdef PWM_FADER_BREATHE_EN
    .breathe    (breathe),
`endif
    .abort      (abort),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic push(input logic [7:0] d, input logic dn, input int c);
    ev_t e;
    e.duty = d;
    e.done = dn;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one command at the current negedge; it is accepted at the next edge
  task automatic send(input logic [7:0] t, input logic [7:0] s, input logic [15:0] d);
    cmd_target = t;
    cmd_step   = s;
    cmd_div    = d;
    cmd_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 20000 && cyc < t; i++) @(negedge clk);
    if (cyc < t) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: reached cyc %0d, expected %0d", cyc, t);
    end
  endtask

  // Monitor: every duty change or done pulse must match the queue head
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      prev = duty;
    end else begin
      if (duty !== prev || done === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: duty=%0d done=%0d cyc=%0d, expected no event",
                   duty, done, cyc);
        end else begin
          e = q.pop_front();
          if (duty !== e.duty || done !== e.done || busy !== !e.done || cyc != e.cyc) begin
            errors++;
            $display("FAIL event: got duty=%0d done=%0d busy=%0d cyc=%0d, expected duty=%0d done=%0d busy=%0d cyc=%0d",
                     duty, done, busy, cyc, e.duty, e.done, !e.done, e.cyc);
          end
        end
      end
      prev = duty;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    cmd_step   = '0;
    cmd_div    = '0;
    abort      = 1'b0;
`ifdef PWM_FADER_BREATHE_EN
    breathe    = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_duty", duty, 0);
    chk("idle_ready", cmd_ready, 1);

    // Ramp up 0 -> 124, step 4, div 9, with an ignored command mid-ramp
    a = cyc + 1;
    for (int k = 1; k <= 31; k++) push(8'(4 * k), (k == 31), a + 10 * k);
    send(8'd124, 8'd4, 16'd9);
    chk("ramp_busy", busy, 1);
    chk("ramp_ready", cmd_ready, 0);
    wait_cyc(a + 55);
    cmd_target = 8'd0;
    cmd_step   = 8'd1;
    cmd_div    = 16'd0;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    wait_cyc(a + 310);

    // Ramp down 124 -> 50, step 10, div 0, partial final step
    a = cyc + 1;
    for (int k = 1; k <= 7; k++) push(8'(124 - 10 * k), 1'b0, a + k);
    push(8'd50, 1'b1, a + 8);
    send(8'd50, 8'd10, 16'd0);
    wait_cyc(a + 8);

    // Back-to-back: saturation 50 -> 255 with step 200
    a = cyc + 1;
    push(8'd250, 1'b0, a + 3);
    push(8'd255, 1'b1, a + 6);
    send(8'd255, 8'd200, 16'd2);
    wait_cyc(a + 6);

    // Return to 0 in one step
    a = cyc + 1;
    push(8'd0, 1'b1, a + 1);
    send(8'd0, 8'd255, 16'd0);
    wait_cyc(a + 1);

    // Abort at duty 37 on a 0 -> 240 ramp
    a = cyc + 1;
    for (int k = 1; k <= 37; k++) push(8'(k), 1'b0, a + 4 * k);
    send(8'd240, 8'd1, 16'd3);
    wait_cyc(a + 148);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_duty", duty, 37);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);

    // New command accepted immediately after abort
    a = cyc + 1;
    push(8'd38, 1'b0, a + 1);
    push(8'd39, 1'b0, a + 2);
    push(8'd40, 1'b1, a + 3);
    send(8'd40, 8'd1, 16'd0);
    wait_cyc(a + 3);

    // target == duty: done one cycle after accept, never busy
    a = cyc + 1;
    push(8'd40, 1'b1, a);
    send(8'd40, 8'd5, 16'd7);
    chk("eq_busy", busy, 0);
    @(negedge clk);
    chk("eq_busy_after", busy, 0);
    chk("eq_done_after", done, 0);

    // cmd_step == 0 behaves as step 1
    a = cyc + 1;
    push(8'd41, 1'b0, a + 2);
    push(8'd42, 1'b0, a + 4);
    push(8'd43, 1'b1, a + 6);
    send(8'd43, 8'd0, 16'd1);
    wait_cyc(a + 6);

    // Abort coincident with the final step
    a = cyc + 1;
    push(8'd44, 1'b0, a + 2);
    send(8'd45, 8'd1, 16'd1);
    wait_cyc(a + 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_last_duty", duty, 44);
    chk("abort_last_done", done, 0);
    chk("abort_last_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("abort_last_hold", duty, 44);

    // Reset mid-ramp
    a = cyc + 1;
    push(8'd49, 1'b0, a + 1);
    push(8'd54, 1'b0, a + 2);
    send(8'd100, 8'd5, 16'd0);
    wait_cyc(a + 2);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_duty", duty, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_hold", duty, 0);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pwm_fader.md
Name: pwm_fader

Overview:
- Duty-cycle ramp controller that drives the `duty` input of the team's `pwm` block.
- Accepts a fade command (target duty, step size, step interval) and moves its registered duty output toward the target, one step per interval.
- Signals completion when the target is reached.
- Sits between firmware/control logic and the `pwm` instance, so LED/motor fades need no per-step CPU involvement.

Parameters:
- DUTY_W, 8, width of duty, target and step (matches the `pwm` duty width).
- DIV_W, 16, width of the step-interval divider.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when a command can be accepted (IDLE).
- cmd_target  in  DUTY_W  target duty.
- cmd_step  in  DUTY_W  duty increment per step; 0 is treated as 1.
- cmd_div  in  DIV_W  clocks between steps, minus 1.
- abort  in  1  stop the ramp and freeze duty.
- duty  out  DUTY_W  registered duty, connects to `pwm.duty`.
- busy  out  1  high while ramping.
- done  out  1  one-cycle pulse when the target is reached.

Behaviour:
- Reset (rst=1 at a clk edge):
  - duty=0, busy=0, done=0, cmd_ready=1.
  - state=IDLE, interval counter=0, latched regs=0.
  - Reset mid-ramp aborts immediately, with the same values.
- States: IDLE, RAMP.
  - cmd_ready = (state==IDLE).
  - busy = (state==RAMP).
- Command acceptance (IDLE with cmd_valid=1 at an edge):
  - Latch target, step (0→1) and div.
  - If target==duty: stay IDLE and pulse done next cycle; busy stays 0.
  - Otherwise: enter RAMP and load counter=div.
  - Commands presented while in RAMP are ignored and are not queued.
- Interval counter (RAMP):
  - Decrements every clk.
  - On the edge where counter==0, a step occurs and the counter reloads div.
  - First duty change lands div+1 edges after the accept edge. Steps are then every div+1 edges.
- Step arithmetic (DUTY_W+1 bit internal math, no wrap):
  - If |target−duty| ≤ step: duty←target, done=1 for that cycle, state←IDLE.
  - Otherwise, duty←duty+step if target>duty, else duty←duty−step.
  - Overflow past 2^DUTY_W−1 and underflow below 0 are impossible by construction.
- Outputs: duty, done and busy change only on clk edges. done and the final duty value update on the same edge.
- abort:
  - In RAMP: go to IDLE next edge, duty holds its current value, no done.
  - In IDLE: abort has no effect. If cmd_valid is also high in IDLE, the command is accepted.
- Simultaneous abort and final step in RAMP: abort wins; duty is unchanged and done is not asserted.
- Back-to-back commands: a command can be accepted on the edge immediately after the done pulse (cmd_ready is high in that cycle).

Optional Feature:
- Macro: PWM_FADER_BREATHE_EN.
- When defined:
  - Adds input `breathe` (1 bit), sampled at command acceptance.
  - If breathe=1, on reaching the target the block latches the start duty as the new target and keeps ramping in RAMP, ping-ponging between the two endpoints indefinitely.
  - done pulses at every endpoint arrival; only abort or rst stops the loop.
  - If start==target, the block behaves as the non-breathe case.
- When undefined: no `breathe` port; behaviour is exactly as above.

Decomposition:
- Package `pwm_pkg`:
  - DUTY_W default constant.
  - State encoding constants (IDLE, RAMP).
  - Shared with `pwm` so duty widths stay consistent.
- One natural sub-module, `fade_tick_gen`:
  - Loadable down-counter, DIV_W wide.
  - Inputs: load, div value, enable.
  - Output: tick when the count reaches 0, with auto-reload.
- Step arithmetic and the FSM live in `pwm_fader`.

Test Plan:
- Reset: hold rst 3 cycles → duty=0, busy=0, done=0, cmd_ready=1; after release, outputs stay static with no command.
- Ramp up: duty=0, target=124, step=4, div=9 → duty=4 at edge 10 after accept, +4 every 10 edges, duty=124 with done at edge 310, busy low the next cycle.
- Ramp down, partial final step: from 124, target=50, step=10, div=0 → 114,104,…,54,50 on consecutive edges (8 steps), done with duty=50, no underflow.
- Saturation: from 50, target=255, step=200 → 250 then 255, done, duty never wraps.
- Abort: start 0→240, step=1, div=3; assert abort when duty=37 → duty stays 37, no done, cmd_ready=1 next cycle; a new command is accepted immediately.
- Edge cases:
  - target==duty → done one cycle after accept, busy never high.
  - cmd_step=0 → behaves as step=1.
  - abort coincident with the final step → duty unchanged, no done.
